// File: rtl/libeth.sv
// libeth: shared engine state encoding, command-entry layout and broadcast id
package libeth;

    localparam logic [7:0] BCASTPID = 8'hFF;

    typedef enum logic [2:0] {IDLE, CMD, DROP, ISSUE, WAIT, ACK} state_t;

    // desc carries the raw low 31 bits of the even word; buf/count/tid are sliced by the engine
    typedef struct packed {
        logic [29:0] addr;
        logic [30:0] desc;
    } cmd_t;

endpackage

// File: rtl/eth_dma_cmd_engine_if.sv
// eth_dma_cmd_engine_if: rx word stream, DMA issue port and ack request port
interface eth_dma_cmd_engine_if #(
    parameter int BUFW = 10,
    parameter int TIDW = 6
);
    logic            rx_valid, rx_sop, rx_eop, rx_err, rx_iscmd;
    logic [31:0]     rx_data;
    logic [7:0]      rx_pid;
    logic [15:0]     rx_seq;
    logic            dma_valid, dma_ready, dma_done;
    logic [29:0]     dma_addr;
    logic [BUFW-1:0] dma_buf, dma_count;
    logic [TIDW-1:0] dma_tid;
    logic            ack_valid, ack_ready, ack_nack;
    logic [15:0]     ack_seq;

    modport master (
        input  rx_valid, rx_sop, rx_eop, rx_err, rx_iscmd, rx_data, rx_pid, rx_seq,
        input  dma_ready, dma_done, ack_ready,
        output dma_valid, dma_addr, dma_buf, dma_count, dma_tid,
        output ack_valid, ack_nack, ack_seq
    );

    modport slave (
        output rx_valid, rx_sop, rx_eop, rx_err, rx_iscmd, rx_data, rx_pid, rx_seq,
        output dma_ready, dma_done, ack_ready,
        input  dma_valid, dma_addr, dma_buf, dma_count, dma_tid,
        input  ack_valid, ack_nack, ack_seq
    );
endinterface

// File: rtl/eth_cmd_fifo.sv
// eth_cmd_fifo: LUTRAM command FIFO with a registered head stage, flush, full and empty
module eth_cmd_fifo #(
    parameter int DEPTH = 16,
    parameter int W = 61
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         valid,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt;
    logic          ld, wr;

    // full counts the head register too, so total capacity is exactly DEPTH
    assign full  = (cnt + (AW+1)'(valid)) == (AW+1)'(DEPTH);
    assign empty = !valid && cnt == '0;
    assign wr    = push && !full;
    assign ld    = cnt != '0 && (!valid || pop);

    // storage array, no reset so it maps onto distributed RAM
    always_ff @(posedge clk)
        if (wr) mem[wp] <= din;

    // pointers and head register; the head refills from RAM whenever it is free or popped
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp    <= '0;
            rp    <= '0;
            cnt   <= '0;
            valid <= 1'b0;
            dout  <= '0;
        end else if (flush) begin
            wp    <= '0;
            rp    <= '0;
            cnt   <= '0;
            valid <= 1'b0;
        end else begin
            if (wr) wp <= wp + AW'(1);
            if (ld) begin
                dout  <= mem[rp];
                rp    <= rp + AW'(1);
                valid <= 1'b1;
            end else if (pop) valid <= 1'b0;
            cnt <= cnt + (AW+1)'(wr) - (AW+1)'(ld);
        end
    end
endmodule

// File: rtl/eth_dma_cmd_engine.sv
// eth_dma_cmd_engine: turns command packets into DMA issues and acks them; ETH_DMA_PARITY_EN adds even-word parity checking
module eth_dma_cmd_engine
    import libeth::*;
#(
    parameter int         FIFO_DEPTH = 16,
    parameter int         MAX_OUT    = 4,
    parameter int         BUFW       = 10,
    parameter int         TIDW       = 6,
    parameter logic [7:0] MYPID      = 8'h00
) (
    input  logic                 clk,
    input  logic                 reset_n,
    eth_dma_cmd_engine_if.master bus,
    output logic                 busy,
    output logic                 ovf_err,
    output logic                 done_err,
    output logic                 par_err
);
    localparam int             OW   = $clog2(MAX_OUT + 1);
    localparam logic [OW-1:0]  MAXO = OW'(MAX_OUT);

    state_t        state, nstate;
    logic          phase_odd, nack;
    logic [15:0]   tmp_seq, last_seq;
    logic [29:0]   addr_q;
    logic [OW-1:0] outst;
    cmd_t          head, din;
    logic          f_valid, f_empty, f_full;
    logic          hdr_ok, eop, push, par_bad, push_bad, bad_end, flush, acc;
    logic          unused_bits;

    assign hdr_ok   = bus.rx_valid && bus.rx_sop && bus.rx_iscmd && (bus.rx_pid == MYPID || bus.rx_pid == BCASTPID);
    assign eop      = bus.rx_valid && bus.rx_eop;
    assign push     = state == CMD && bus.rx_valid && !phase_odd;
    assign push_bad = (push && f_full) || par_bad;
    // phase_odd at the end word means the packet closes on an unpaired address
    assign bad_end  = bus.rx_err || phase_odd || nack || push_bad;
    assign flush    = state == CMD && eop && bad_end;
    assign acc      = bus.dma_valid && bus.dma_ready;
    assign din      = '{addr: addr_q, desc: bus.rx_data[30:0]};

    assign bus.dma_valid = state == ISSUE && f_valid && outst < MAXO;
    assign bus.dma_addr  = head.addr;
    assign bus.dma_buf   = head.desc[2*BUFW-1:BUFW];
    assign bus.dma_count = head.desc[BUFW-1:0];
    assign bus.dma_tid   = head.desc[2*BUFW +: TIDW];
    assign bus.ack_valid = state == ACK;
    assign bus.ack_nack  = state == ACK && nack;
    assign bus.ack_seq   = state == ACK ? last_seq : '0;
    assign busy          = state != IDLE;
    assign unused_bits   = ^{head.desc, bus.rx_data[31]};

`ifdef ETH_DMA_PARITY_EN
    assign par_bad = push && ^bus.rx_data;
    // parity failures stay flagged until reset
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) par_err <= 1'b0;
        else if (par_bad) par_err <= 1'b1;
`else
    assign par_bad = 1'b0;
    assign par_err = 1'b0;
`endif

    eth_cmd_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(cmd_t))) u_fifo (
        .clk(clk), .reset_n(reset_n), .push(push), .pop(acc), .flush(flush),
        .din(din), .dout(head), .valid(f_valid), .empty(f_empty), .full(f_full)
    );

    // state register
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= nstate;

    // packet-level sequencing; stray sop outside IDLE is simply not looked at
    always_comb begin
        nstate = state;
        unique case (state)
            IDLE:  if (hdr_ok) nstate = bus.rx_seq == last_seq ? DROP : CMD;
            CMD:   if (eop) nstate = bad_end ? ACK : ISSUE;
            DROP:  if (eop) nstate = ACK;
            ISSUE: if (f_empty) nstate = WAIT;
            WAIT:  if (outst == '0) nstate = ACK;
            ACK:   if (bus.ack_ready) nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // packet bookkeeping, in-flight count and sticky errors
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_odd <= 1'b0;
            nack      <= 1'b0;
            tmp_seq   <= '0;
            last_seq  <= 16'hFFFF;
            addr_q    <= '0;
            outst     <= '0;
            ovf_err   <= 1'b0;
            done_err  <= 1'b0;
        end else begin
            if (state == IDLE && hdr_ok) begin
                tmp_seq   <= bus.rx_seq;
                phase_odd <= 1'b1;
            end
            if (state == CMD && bus.rx_valid) begin
                phase_odd <= !phase_odd;
                if (phase_odd) addr_q <= bus.rx_data[29:0];
            end
            if (push_bad) nack <= 1'b1;
            if (state == CMD && eop) begin
                if (bad_end) nack <= 1'b1;
                else last_seq <= tmp_seq;
            end
            if (state == DROP && eop) nack <= bus.rx_err;
            if (state == ACK && bus.ack_ready) nack <= 1'b0;
            if (push && f_full) ovf_err <= 1'b1;
            if (bus.dma_done && outst == '0) done_err <= 1'b1;
            if (acc && !bus.dma_done) outst <= outst + OW'(1);
            else if (bus.dma_done && !acc && outst != '0) outst <= outst - OW'(1);
        end
    end
endmodule

// File: tb/tb_eth_dma_cmd_engine.sv
// tb_eth_dma_cmd_engine: random packet traffic checked against a packet-level reference model
module tb_eth_dma_cmd_engine;
    localparam int         FD  = 4;
    localparam int         MO  = 2;
    localparam int         BW  = 10;
    localparam int         TW  = 6;
    localparam logic [7:0] PID = 8'h3C;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic busy, ovf_err, done_err, par_err;

    eth_dma_cmd_engine_if #(.BUFW(BW), .TIDW(TW)) bus ();

    eth_dma_cmd_engine #(.FIFO_DEPTH(FD), .MAX_OUT(MO), .BUFW(BW), .TIDW(TW), .MYPID(PID)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .busy(busy), .ovf_err(ovf_err), .done_err(done_err), .par_err(par_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: last accepted sequence, expected issue list, sticky flags
    logic [15:0] m_last = 16'hFFFF;
    logic [55:0] exp_q[$];
    logic        m_ovf = 1'b0, m_par = 1'b0, m_done = 1'b0;
    logic        exp_ack, exp_nack;
    logic [15:0] exp_seq;

    // DMA responder state
    int          pend_n = 0, credit = 0, n_issued = 0;
    logic        auto_done = 1'b1, stall = 1'b0;
    logic [55:0] held;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [55:0] dma_fields();
        return {bus.dma_addr, bus.dma_buf, bus.dma_count, bus.dma_tid};
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // DMA target: random ready, done pulses either automatic or on request
    initial begin
        bus.dma_ready = 1'b0;
        bus.dma_done  = 1'b0;
        forever begin
            @(negedge clk);
            bus.dma_done = 1'b0;
            if (!reset_n) begin
                stall = 1'b0;
                bus.dma_ready = 1'b0;
                continue;
            end
            if (stall) begin
                check("dma_hold_valid", bus.dma_valid, 1);
                check("dma_hold_data", dma_fields(), held);
            end
            if (bus.dma_valid) check("max_out", pend_n < MO, 1);
            bus.dma_ready = $urandom_range(0, 3) != 0;
            stall = bus.dma_valid && !bus.dma_ready;
            held  = dma_fields();
            if (auto_done ? (pend_n > 0 && $urandom_range(0, 2) == 0) : credit > 0) begin
                bus.dma_done = 1'b1;
                if (!auto_done) credit--;
                if (pend_n == 0) m_done = 1'b1;
                else pend_n--;
            end
            if (bus.dma_valid && bus.dma_ready) begin
                n_issued++;
                check("issue_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("issue", dma_fields(), exp_q.pop_front());
                pend_n++;
            end
        end
    end

    task automatic send_pkt(input logic [7:0] pid, input logic iscmd, input logic [15:0] seq,
                            input int nw, input logic err, input logic badpar);
        logic [31:0] w[$];
        logic [31:0] d;
        logic        hit, pb, bad;
        pb = 1'b0;
        for (int i = 0; i < nw; i++) begin
            d = $urandom;
`ifdef ETH_DMA_PARITY_EN
            if (i % 2 == 1) begin
                d[31] = (^d[30:0]) ^ (badpar && i == 1);
                pb = pb | (badpar && i == 1);
            end
`endif
            w.push_back(d);
        end
        hit = iscmd && (pid == PID || pid == 8'hFF);
        exp_ack = hit;
        if (hit) begin
            if (seq == m_last) begin
                exp_seq  = m_last;
                exp_nack = err;
            end else begin
                bad = err || (nw % 2 == 1) || (nw / 2 > FD) || pb;
                m_ovf = m_ovf | (nw / 2 > FD);
                m_par = m_par | pb;
                if (bad) begin
                    exp_seq  = m_last;
                    exp_nack = 1'b1;
                end else begin
                    for (int i = 0; i + 1 < nw; i += 2)
                        exp_q.push_back({w[i][29:0], w[i+1][19:10], w[i+1][9:0], w[i+1][25:20]});
                    m_last   = seq;
                    exp_seq  = seq;
                    exp_nack = 1'b0;
                end
            end
        end
        @(negedge clk);
        bus.rx_valid = 1'b1; bus.rx_sop = 1'b1; bus.rx_eop = 1'b0; bus.rx_err = 1'b0;
        bus.rx_pid = pid; bus.rx_seq = seq; bus.rx_iscmd = iscmd; bus.rx_data = $urandom;
        for (int i = 0; i < nw; i++) begin
            @(negedge clk);
            bus.rx_valid = 1'b0; bus.rx_sop = 1'b0; bus.rx_eop = 1'b0;
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            bus.rx_valid = 1'b1;
            bus.rx_sop   = hit && $urandom_range(0, 7) == 0;
            bus.rx_data  = w[i];
            bus.rx_eop   = i == nw - 1;
            bus.rx_err   = err && i == nw - 1;
            if (hit) begin
                bus.rx_pid = 8'($urandom); bus.rx_seq = 16'($urandom); bus.rx_iscmd = 1'($urandom);
            end
        end
        @(negedge clk);
        bus.rx_valid = 1'b0; bus.rx_sop = 1'b0; bus.rx_eop = 1'b0; bus.rx_err = 1'b0;
    endtask

    task automatic finish_pkt();
        int k = 0;
        if (exp_ack) begin
            while (!bus.ack_valid && k < 3000) begin
                @(negedge clk);
                k++;
            end
            check("ack_arrives", bus.ack_valid, 1);
            if (bus.ack_valid) begin
                check("ack_seq", bus.ack_seq, exp_seq);
                check("ack_nack", bus.ack_nack, exp_nack);
                check("all_issued", exp_q.size(), 0);
                check("none_in_flight", pend_n, 0);
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    check("ack_hold", bus.ack_valid, 1);
                end
                bus.ack_ready = 1'b1;
                @(negedge clk);
                bus.ack_ready = 1'b0;
                check("idle_after_ack", busy, 0);
            end
        end else begin
            repeat (3) @(negedge clk);
            check("ignored_not_busy", busy, 0);
            check("ignored_no_ack", bus.ack_valid, 0);
        end
        check("ovf_err", ovf_err, m_ovf);
        check("done_err", done_err, m_done);
        check("par_err", par_err, m_par);
    endtask

    task automatic reset_model();
        m_last = 16'hFFFF;
        exp_q.delete();
        pend_n = 0;
        m_ovf = 1'b0; m_par = 1'b0; m_done = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_dma"}, {bus.dma_valid, dma_fields()}, 0);
        check({tag, "_ack"}, {bus.ack_valid, bus.ack_nack, bus.ack_seq}, 0);
        check({tag, "_errs"}, {ovf_err, done_err, par_err}, 0);
    endtask

    initial begin
        int n0, k;
        logic [7:0]  pid;
        logic [15:0] seq;
        bus.rx_valid = 1'b0; bus.rx_sop = 1'b0; bus.rx_eop = 1'b0; bus.rx_err = 1'b0;
        bus.rx_iscmd = 1'b0; bus.rx_data = '0; bus.rx_pid = '0; bus.rx_seq = '0;
        bus.ack_ready = 1'b0;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        reset_n = 1'b1;

        send_pkt(PID, 1'b1, 16'd5, 4, 1'b0, 1'b0);
        finish_pkt();
        send_pkt(PID, 1'b1, 16'd5, 4, 1'b0, 1'b0);
        finish_pkt();
        send_pkt(PID, 1'b1, 16'd9, 6, 1'b1, 1'b0);
        finish_pkt();
        send_pkt(PID, 1'b1, 16'd9, 2, 1'b0, 1'b0);
        finish_pkt();
        send_pkt(PID, 1'b1, 16'd11, 3, 1'b0, 1'b0);
        finish_pkt();

        auto_done = 1'b0;
        n0 = n_issued;
        send_pkt(8'hFF, 1'b1, 16'd12, 8, 1'b0, 1'b0);
        repeat (12) @(negedge clk);
        check("maxout_stall_count", n_issued - n0, 2);
        check("maxout_stall_valid", bus.dma_valid, 0);
        credit = 1;
        repeat (8) @(negedge clk);
        check("maxout_after_done1", n_issued - n0, 3);
        credit = 1;
        repeat (8) @(negedge clk);
        check("maxout_after_done2", n_issued - n0, 4);
        auto_done = 1'b1;
        finish_pkt();

        send_pkt(PID, 1'b1, 16'd20, 10, 1'b0, 1'b0);
        finish_pkt();
        send_pkt(PID, 1'b1, 16'd21, 4, 1'b0, 1'b1);
        finish_pkt();
        send_pkt(8'h55, 1'b1, 16'd22, 4, 1'b0, 1'b0);
        finish_pkt();
        send_pkt(PID, 1'b0, 16'd23, 4, 1'b0, 1'b0);
        finish_pkt();

        auto_done = 1'b0;
        n0 = n_issued;
        send_pkt(PID, 1'b1, 16'd30, 6, 1'b0, 1'b0);
        k = 0;
        while (n_issued - n0 < 2 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("reach_issue", n_issued - n0, 2);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_zero_outputs("midissue_reset");
        reset_model();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        credit = 1;
        repeat (4) @(negedge clk);
        check("late_done_err", done_err, m_done);
        @(negedge clk);
        reset_n = 1'b0;
        reset_model();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        check("done_err_cleared", done_err, m_done);
        auto_done = 1'b1;

        for (int p = 0; p < 16; p++) begin
            k   = $urandom_range(0, 9);
            pid = k == 0 ? 8'h55 : k == 1 ? 8'hFF : PID;
            seq = $urandom_range(0, 3) == 0 ? m_last : 16'($urandom);
            send_pkt(pid, $urandom_range(0, 9) != 0, seq, $urandom_range(1, 2 * FD + 1),
                     $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
            finish_pkt();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
